// File: rtl/scan_mux_if.sv
// scan_mux_if: data/control/status bundle between a display front-end and scan_mux.
interface scan_mux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      hold;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          ch_idx;
  logic [CHANNELS-1:0]       ch_en;
  logic                      wrap;

  modport master (
    output data_in, mode, sel, hold,
    input  out, ch_idx, ch_en, wrap
  );

  modport slave (
    input  data_in, mode, sel, hold,
    output out, ch_idx, ch_en, wrap
  );
endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel selector with manual select and prescaled round-robin scan.
// Define SCAN_MUX_BLANK_EN to blank ch_en for BLANK cycles after every index change.
module scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DIV      = 50000,
  parameter int BLANK    = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  scan_mux_if.slave bus
);
  localparam int PC_W = $clog2(DIV);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
  localparam logic [PC_W-1:0]  PC_MAX   = PC_W'(DIV - 1);

  if (CHANNELS < 2 || CHANNELS > 16 || (2 ** SEL_W) < CHANNELS || DIV < 2 || BLANK < 0) begin : g_bad_param
    $error("scan_mux: illegal parameter set");
  end

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [SEL_W-1:0]    ch_idx_q, ch_idx_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [CHANNELS-1:0] ch_en_q, ch_en_d;
  logic                wrap_q, wrap_d;
  logic [SEL_W-1:0]    nidx;
  logic [CHANNELS-1:0] onehot;

  // Next index, prescaler and wrap pulse from mode, hold and scan position.
  always_comb begin
    pc_d   = pc_q;
    nidx   = ch_idx_q;
    wrap_d = 1'b0;
    if (!bus.mode) begin
      pc_d = {PC_W{1'b0}};
      // Widened compare keeps the clamp meaningful when CHANNELS < 2**SEL_W.
      if ({1'b0, bus.sel} > {1'b0, LAST_IDX}) begin
        nidx = LAST_IDX;
      end else begin
        nidx = bus.sel;
      end
    end else if (bus.hold) begin
      pc_d = pc_q;
    end else if (pc_q == PC_MAX) begin
      pc_d = {PC_W{1'b0}};
      if (ch_idx_q == LAST_IDX) begin
        nidx   = {SEL_W{1'b0}};
        wrap_d = 1'b1;
      end else begin
        nidx = ch_idx_q + SEL_W'(1);
      end
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
    ch_idx_d = nidx;
  end

  // Channel data and one-hot enable for the next index.
  always_comb begin
    out_d  = {WIDTH{1'b0}};
    onehot = {CHANNELS{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      onehot[k] = (nidx == SEL_W'(k));
      out_d     = out_d | (bus.data_in[k*WIDTH +: WIDTH] & {WIDTH{onehot[k]}});
    end
  end

`ifdef SCAN_MUX_BLANK_EN
  localparam int BL_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  if (BLANK < 1 || BLANK >= DIV) begin : g_bad_blank
    $error("scan_mux: BLANK must satisfy 1 <= BLANK < DIV");
  end

  logic [BL_W-1:0] blank_q, blank_d;

  // Blank counter: the change edge itself is the first blanked cycle.
  always_comb begin
    blank_d = blank_q;
    ch_en_d = onehot;
    if (nidx != ch_idx_q) begin
      blank_d = BL_W'(BLANK - 1);
      ch_en_d = {CHANNELS{1'b0}};
    end else if (blank_q != {BL_W{1'b0}}) begin
      blank_d = blank_q - BL_W'(1);
      ch_en_d = {CHANNELS{1'b0}};
    end else begin
      blank_d = {BL_W{1'b0}};
      ch_en_d = onehot;
    end
  end

  // Blank counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q <= {BL_W{1'b0}};
    end else begin
      blank_q <= blank_d;
    end
  end
`else
  // Enable follows the selected index with no gap.
  always_comb begin
    ch_en_d = onehot;
  end
`endif

  // Output and scan state registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= {PC_W{1'b0}};
      ch_idx_q <= {SEL_W{1'b0}};
      out_q    <= {WIDTH{1'b0}};
      ch_en_q  <= {CHANNELS{1'b0}};
      wrap_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ch_idx_q <= ch_idx_d;
      out_q    <= out_d;
      ch_en_q  <= ch_en_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.ch_idx = ch_idx_q;
  assign bus.ch_en  = ch_en_q;
  assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: randomized and directed checks of scan_mux against a cycle-level reference model.
module tb_scan_mux;
  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;
  localparam int DIV      = 4;
  localparam int BLANK    = 2;
  localparam int W_ALL    = WIDTH + SEL_W + CHANNELS + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scan_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

  scan_mux #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DIV(DIV), .BLANK(BLANK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which channel is shown and how long it has been shown in auto mode.
  int                  m_idx   = 0;
  int                  m_dwell = 0;
  int                  m_blank = 0;
  logic                m_wrap  = 1'b0;
  logic [WIDTH-1:0]    m_out   = '0;
  logic [CHANNELS-1:0] m_en    = '0;

  logic [W_ALL-1:0] obs;
  assign obs = {bus.out, bus.ch_idx, bus.ch_en, bus.wrap};

  function automatic logic [W_ALL-1:0] expv();
    return {m_out, SEL_W'(m_idx), m_en, m_wrap};
  endfunction

  // Apply the model for the inputs present at the coming edge, then advance past it.
  task automatic tick();
    int prev;
    prev = m_idx;
    if (!rst_n) begin
      m_idx = 0; m_dwell = 0; m_blank = 0; m_wrap = 1'b0;
      m_out = '0; m_en = '0;
    end else begin
      m_wrap = 1'b0;
      if (!bus.mode) begin
        m_idx   = (int'(bus.sel) < CHANNELS) ? int'(bus.sel) : CHANNELS - 1;
        m_dwell = 0;
      end else if (!bus.hold) begin
        m_dwell++;
        if (m_dwell == DIV) begin
          m_dwell = 0;
          m_wrap  = (m_idx == CHANNELS - 1);
          m_idx   = (m_idx + 1) % CHANNELS;
        end
      end
      m_out = WIDTH'(bus.data_in >> (m_idx * WIDTH));
      m_en  = CHANNELS'(1) << m_idx;
`ifdef SCAN_MUX_BLANK_EN
      if (m_idx != prev) m_blank = BLANK;
      if (m_blank > 0) begin
        m_en = '0;
        m_blank--;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.data_in = 16'hD5A3; bus.mode = 1'b1; bus.sel = 2'd0; bus.hold = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== {W_ALL{1'b0}}) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, {W_ALL{1'b0}});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.out !== 4'h3 || bus.ch_en !== 4'b0001 || obs !== expv()) begin
      errors++; $display("FAIL reset_release: got out=%h en=%b expected out=3 en=0001", bus.out, bus.ch_en);
    end
  endtask

  task automatic test_manual();
    bus.mode = 1'b0; bus.sel = 2'd2;
    tick();
    checks++;
    if (bus.out !== 4'h5 || bus.ch_idx !== 2'd2 || obs !== expv()) begin
      errors++; $display("FAIL manual_sel2: got %h expected %h (out=5)", obs, expv());
    end
    bus.sel = 2'd3;
    tick();
    checks++;
    if (bus.out !== 4'hD || bus.ch_idx !== 2'd3 || obs !== expv()) begin
      errors++; $display("FAIL manual_sel3: got %h expected %h (out=D)", obs, expv());
    end
    for (int i = 0; i < 16; i++) begin
      bus.sel     = SEL_W'($urandom_range(0, CHANNELS - 1));
      bus.data_in = 16'($urandom);
      bus.hold    = 1'($urandom);
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL manual_rand: got %h expected %h", obs, expv());
      end
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_auto_scan();
    int wraps;
    bus.data_in = 16'hD5A3; bus.mode = 1'b0; bus.sel = 2'd0;
    tick();
    bus.mode = 1'b1;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.wrap === 1'b1) wraps++;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL auto_seq: cycle %0d got %h expected %h", i, obs, expv());
      end
      if (i == 15) begin
        checks++;
        if (bus.wrap !== 1'b1 || bus.out !== 4'h3) begin
          errors++; $display("FAIL auto_wrap_edge: got wrap=%b out=%h expected wrap=1 out=3", bus.wrap, bus.out);
        end
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL auto_wrap_count: got %0d expected 1", wraps);
    end
  endtask

  task automatic test_hold();
    bus.mode = 1'b0; bus.sel = 2'd1;
    tick();
    bus.mode = 1'b1; bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) bus.data_in = 16'hD573;
      tick();
      checks++;
      if (obs !== expv() || bus.ch_idx !== 2'd1 || bus.wrap !== 1'b0) begin
        errors++; $display("FAIL hold_frozen: cycle %0d got %h expected %h", i, obs, expv());
      end
      if (i == 5) begin
        checks++;
        if (bus.out !== 4'h7) begin
          errors++; $display("FAIL hold_data_track: got %h expected 7", bus.out);
        end
      end
    end
    bus.hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL hold_release: cycle %0d got %h expected %h", i, obs, expv());
      end
    end
    checks++;
    if (bus.ch_idx !== 2'd2 || bus.out !== 4'h5) begin
      errors++; $display("FAIL hold_step: got idx=%0d out=%h expected idx=2 out=5", bus.ch_idx, bus.out);
    end
  endtask

  task automatic test_midscan();
    int budget;
    bus.data_in = 16'hD5A3; bus.mode = 1'b1; bus.hold = 1'b0;
    budget = 40;
    while (bus.ch_idx !== 2'd2 && budget > 0) begin
      tick();
      budget--;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL midscan_run: got %h expected %h", obs, expv());
      end
    end
    checks++;
    if (budget == 0) begin
      errors++; $display("FAIL midscan_reach_ch2: got idx=%0d expected 2 within budget", bus.ch_idx);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs !== {W_ALL{1'b0}}) begin
      errors++; $display("FAIL midscan_reset: got %h expected %h", obs, {W_ALL{1'b0}});
    end
    rst_n = 1'b1;
    budget = 40;
    while (bus.ch_idx !== 2'd3 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0 || obs !== expv()) begin
      errors++; $display("FAIL midscan_reach_ch3: got %h expected %h", obs, expv());
    end
    bus.mode = 1'b0; bus.sel = 2'd0;
    tick();
    checks++;
    if (bus.out !== 4'h3 || bus.wrap !== 1'b0 || bus.ch_idx !== 2'd0 || obs !== expv()) begin
      errors++; $display("FAIL mode_switch: got %h expected %h (out=3 wrap=0)", obs, expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      bus.mode = ($urandom_range(0, 5) != 0);
      bus.hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) bus.sel = SEL_W'($urandom);
      if ($urandom_range(0, 2) == 0) bus.data_in = 16'($urandom);
      tick();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL random: cycle %0d got %h expected %h", i, obs, expv());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_scan();
    test_hold();
    test_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
